// File: rtl/serv_wb_ram_resp.sv
// Wishbone classic RAM responder for the SERV data bus: programmable wait states, byte-lane writes, registered reads.
// Optional select-pattern checking is enabled by defining SERV_WB_RAM_SEL_CHECK_EN.
module serv_wb_ram_resp #(
    parameter int AW   = 8,
    parameter int WAIT = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_sel_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam logic [7:0] WAIT_INIT = (WAIT > 0) ? 8'(WAIT - 1) : 8'd0;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdt_q;
    logic        enterAck;
    logic        wrEn;
    logic        rdEn;
    logic [3:0]  laneWe;
    logic [AW-1:0] wordIdx;
    logic [31:0] mem [2**AW];

    logic unused_adr;
    assign unused_adr = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0]};

    assign wordIdx = i_wb_adr[AW+1:2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        enterAck = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_wb_cyc) begin
                    if (WAIT > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d  = S_ACK;
                        enterAck = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 8'd0) begin
                    state_d  = S_ACK;
                    enterAck = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A clock edge arriving while reset is held must never commit a write.
    assign wrEn = enterAck & i_wb_we & ~i_rst;
    assign rdEn = enterAck & ~i_wb_we;

`ifdef SERV_WB_RAM_SEL_CHECK_EN
    logic selLegal;
    logic sel_err_q;

    always_comb begin
        case (i_wb_sel)
            4'b1111, 4'b0011, 4'b1100,
            4'b0001, 4'b0010, 4'b0100, 4'b1000: selLegal = 1'b1;
            default:                            selLegal = 1'b0;
        endcase
    end

    assign laneWe = {4{wrEn & selLegal}} & i_wb_sel;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sel_err_q <= 1'b0;
        end else if (wrEn && !selLegal) begin
            sel_err_q <= 1'b1;
        end
    end

    assign o_sel_err = sel_err_q;
`else
    assign laneWe    = {4{wrEn}} & i_wb_sel;
    assign o_sel_err = 1'b0;
`endif

    // RAM contents deliberately survive reset.
    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 4; n++) begin
            if (laneWe[n]) begin
                mem[wordIdx][8*n +: 8] <= i_wb_dat[8*n +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdt_q <= 32'd0;
        end else if (rdEn) begin
            rdt_q <= mem[wordIdx];
        end
    end

    assign o_wb_rdt = rdt_q;
    assign o_wb_ack = (state_q == S_ACK);

endmodule

// File: tb/tb_serv_wb_ram_resp.sv
// Self-checking bench for serv_wb_ram_resp: three instances (WAIT=1, 3, 0) share the bus signals, each with its own cyc.
// Directed vector table, hand-written corner sequences, then randomized traffic against a word-level memory model.
module tb_serv_wb_ram_resp;

    logic        clk;
    logic        rst;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cyc;
    logic [31:0] rdtW [3];
    logic        ackW [3];
    logic        errW [3];

    int nChecks;
    int nFails;

    logic [31:0] memModel [3][256];
    logic [31:0] rdtModel [3];
    logic        errModel [3];

    serv_wb_ram_resp #(.AW(8), .WAIT(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc[0]), .o_wb_rdt(rdtW[0]), .o_wb_ack(ackW[0]), .o_sel_err(errW[0])
    );
    serv_wb_ram_resp #(.AW(8), .WAIT(3)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc[1]), .o_wb_rdt(rdtW[1]), .o_wb_ack(ackW[1]), .o_sel_err(errW[1])
    );
    serv_wb_ram_resp #(.AW(8), .WAIT(0)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc[2]), .o_wb_rdt(rdtW[2]), .o_wb_ack(ackW[2]), .o_sel_err(errW[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          k;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] expRdt;
        logic        expErr;
    } vec_t;

    vec_t vecs [18];

`ifdef SERV_WB_RAM_SEL_CHECK_EN
    localparam logic        ERR_BAD = 1'b1;
    localparam logic [31:0] RD_BAD  = 32'h55663344;
    localparam logic [31:0] RD_LAST = 32'h55663377;
`else
    localparam logic        ERR_BAD = 1'b0;
    localparam logic [31:0] RD_BAD  = 32'h55FFFF44;
    localparam logic [31:0] RD_LAST = 32'h55FFFF77;
`endif

    function automatic int waitOf(input int k);
        return (k == 0) ? 1 : (k == 1) ? 3 : 0;
    endfunction

    function automatic bit selAllowed(input logic [3:0] s);
`ifdef SERV_WB_RAM_SEL_CHECK_EN
        return s inside {4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
`else
        return 1'b1;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        for (int k = 0; k < 3; k++) begin
            rdtModel[k] = 32'd0;
            errModel[k] = 1'b0;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that leaves ACK.
    task automatic applyStimulus(input int k, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s, input bit scramble);
        int n;
        int lat;
        int idx;
        lat = waitOf(k) + 1;
        idx = int'(a[9:2]);
        if (scramble && lat > 1) begin
            adr = $urandom; dat = $urandom; sel = 4'($urandom); we = 1'($urandom);
        end else begin
            adr = a; dat = d; sel = s; we = w;
        end
        cyc[k] = 1'b1;
        n = 0;
        while (!ackW[k] && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (n == lat - 1) begin
                adr = a; dat = d; sel = s; we = w;
            end
        end
        checkOutput("ackLatency", 32'(n), 32'(lat));
        if (w) begin
            if (selAllowed(s)) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) memModel[k][idx][8*b +: 8] = d[8*b +: 8];
            end else begin
                errModel[k] = 1'b1;
            end
        end else begin
            rdtModel[k] = memModel[k][idx];
        end
        cyc[k] = 1'b0;
        adr = $urandom; dat = $urandom; sel = 4'($urandom); we = 1'($urandom);
        checkOutput("rdtModel", rdtW[k], rdtModel[k]);
        checkOutput("selErrModel", 32'(errW[k]), 32'(errModel[k]));
        @(posedge clk); #1;
        checkOutput("ackOneCycle", 32'(ackW[k]), 32'd0);
    endtask

    initial begin
        int ackSeen;
        nChecks = 0;
        nFails  = 0;
        rst = 1'b1; cyc = 3'b000; adr = 32'd0; dat = 32'd0; sel = 4'd0; we = 1'b0;
        resetModel();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("resetAck", 32'(ackW[k]), 32'd0);
            checkOutput("resetRdt", rdtW[k], 32'd0);
            checkOutput("resetSelErr", 32'(errW[k]), 32'd0);
        end

        vecs[0]  = '{0, 1'b1, 32'h10,  32'hDEADBEEF, 4'b1111, 32'h0,        1'b0};
        vecs[1]  = '{0, 1'b0, 32'h10,  32'h0,        4'b0000, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{0, 1'b1, 32'h10,  32'h11223344, 4'b1111, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{0, 1'b1, 32'h10,  32'h00AA0000, 4'b0100, 32'hDEADBEEF, 1'b0};
        vecs[4]  = '{0, 1'b0, 32'h10,  32'h0,        4'b1111, 32'h11AA3344, 1'b0};
        vecs[5]  = '{0, 1'b1, 32'h10,  32'h55660000, 4'b1100, 32'h11AA3344, 1'b0};
        vecs[6]  = '{0, 1'b0, 32'h10,  32'h0,        4'b0001, 32'h55663344, 1'b0};
        vecs[7]  = '{0, 1'b1, 32'h10,  32'hFFFFFFFF, 4'b0110, 32'h55663344, ERR_BAD};
        vecs[8]  = '{0, 1'b0, 32'h10,  32'h0,        4'b1111, RD_BAD,       ERR_BAD};
        vecs[9]  = '{0, 1'b1, 32'h13,  32'h00000077, 4'b0001, RD_BAD,       ERR_BAD};
        vecs[10] = '{0, 1'b0, 32'h10,  32'h0,        4'b1111, RD_LAST,      ERR_BAD};
        vecs[11] = '{2, 1'b1, 32'h0,   32'hA0A0A0A0, 4'b1111, 32'h0,        1'b0};
        vecs[12] = '{2, 1'b1, 32'h4,   32'hB1B1B1B1, 4'b1111, 32'h0,        1'b0};
        vecs[13] = '{2, 1'b1, 32'h8,   32'hC2C2C2C2, 4'b1111, 32'h0,        1'b0};
        vecs[14] = '{2, 1'b0, 32'h0,   32'h0,        4'b1111, 32'hA0A0A0A0, 1'b0};
        vecs[15] = '{2, 1'b0, 32'h4,   32'h0,        4'b1111, 32'hB1B1B1B1, 1'b0};
        vecs[16] = '{2, 1'b0, 32'h8,   32'h0,        4'b1111, 32'hC2C2C2C2, 1'b0};
        vecs[17] = '{2, 1'b0, 32'h400, 32'h0,        4'b1111, 32'hA0A0A0A0, 1'b0};

        // Words 4 and 0..2 are written before they are read, so the model starts clean there.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].k, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, 1'b0);
            checkOutput($sformatf("vecRdt%0d", i), rdtW[vecs[i].k], vecs[i].expRdt);
            checkOutput($sformatf("vecErr%0d", i), 32'(errW[vecs[i].k]), 32'(vecs[i].expErr));
        end

        for (int k = 0; k < 3; k++)
            for (int w = 0; w < 16; w++)
                applyStimulus(k, 1'b1, 32'(w * 4), $urandom, 4'b1111, 1'b0);

        // Abort: one cycle in WAIT then cyc drops; nothing must happen.
        adr = 32'h14; dat = 32'hBADBAD00; sel = 4'b1111; we = 1'b1; cyc[1] = 1'b1;
        @(posedge clk); #1;
        cyc[1] = 1'b0;
        ackSeen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ackW[1]) ackSeen++;
        end
        checkOutput("abortNoAck", 32'(ackSeen), 32'd0);
        applyStimulus(1, 1'b0, 32'h14, 32'h0, 4'b1111, 1'b0);

        // Reset mid-WAIT with a write pending.
        adr = 32'h20; dat = 32'h12345678; sel = 4'b1111; we = 1'b1; cyc[1] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        checkOutput("rstWaitAck", 32'(ackW[1]), 32'd0);
        checkOutput("rstWaitRdt", rdtW[1], 32'd0);
        resetModel();
        @(posedge clk); #1;
        cyc[1] = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1, 1'b0, 32'h20, 32'h0, 4'b1111, 1'b0);

        // Reset during ACK: the write already committed, ack drops at once.
        adr = 32'hC; dat = 32'h0F1E2D3C; sel = 4'b1111; we = 1'b1; cyc[0] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("preRstAck", 32'(ackW[0]), 32'd1);
        memModel[0][3] = 32'h0F1E2D3C;
        #2 rst = 1'b1;
        #1;
        checkOutput("rstAckDrop", 32'(ackW[0]), 32'd0);
        resetModel();
        cyc[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(0, 1'b0, 32'hC, 32'h0, 4'b1111, 1'b0);

        for (int i = 0; i < 120; i++) begin
            int k;
            logic [31:0] a;
            k = int'($urandom_range(2, 0));
            a = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(15, 0)) << 2) | ($urandom & 32'h3);
            applyStimulus(k, 1'($urandom), a, $urandom, 4'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/serv_wb_ram_resp.md
Name: serv_wb_ram_resp

Overview:
- Wishbone classic responder: word-organised data RAM serving the data-bus initiator of the bit-serial core.
- Accepts one request per bus cycle and applies a programmable number of wait states.
- Performs byte-lane writes or registered reads, then returns a single-cycle ack.
- Sits on the core's data bus in small SoCs; it is the far end of the core's load/store interface.

Parameters:
- AW, 8: word-address width; the RAM holds 2**AW 32-bit words.
- WAIT, 1: wait states between request detection and ack; legal range 0..255.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_wb_adr  in  32  byte address; word index = i_wb_adr[AW+1:2]; bits [1:0] and bits above AW+1 are ignored (aliasing).
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte-lane select; lane n = bits [8n+7:8n].
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_cyc  in  1  request valid; held by the initiator until ack.
- o_wb_rdt  out  32  read data, registered.
- o_wb_ack  out  1  single-cycle transfer-complete pulse.
- o_sel_err  out  1  sticky flag: illegal select pattern seen (optional feature).

Behaviour:
Reset state (asynchronous, immediate on i_rst):
- o_wb_ack=0, o_wb_rdt=0, o_sel_err=0, FSM=IDLE, wait counter=0.
- RAM contents are not reset; they are preserved across reset.

FSM states: IDLE, WAIT, ACK.
- IDLE: if i_wb_cyc=1, go to WAIT with counter=WAIT-1 when WAIT>0, else go directly to ACK.
- WAIT: if i_wb_cyc=0, abort to IDLE (no write, no ack). Else, if counter=0, go to ACK; otherwise decrement the counter.
- ACK: o_wb_ack=1 for exactly one cycle, then unconditionally go to IDLE.
- o_wb_ack is a Moore output: high only in ACK.

Memory access (on the edge that enters ACK):
- Write: each lane with sel=1 updates its RAM byte; lanes with sel=0 keep their value. o_wb_rdt is unchanged.
- Read: o_wb_rdt is loaded with the full addressed word regardless of i_wb_sel. It holds until the next read.

Latency:
- Ack is asserted WAIT+1 cycles after the first edge that samples i_wb_cyc=1.
- A new transfer can begin no earlier than 1 cycle after ack. The initiator drops i_wb_cyc on the ack edge, so IDLE sees cyc low.

Boundary conditions:
- i_wb_cyc sampled high in IDLE the cycle right after ACK: treated as a new request.
- Address, data, sel and we are sampled only on the ACK-entry edge. Changes during WAIT are legal; the last values win.
- Reset asserted mid-WAIT or during ACK: ack drops immediately and no write occurs, unless the ACK-entry edge has already completed.
- Read-after-write to the same word returns the new data.

Optional Feature:
- Macro: SERV_WB_RAM_SEL_CHECK_EN.
- Legal select patterns: 1111, 0011, 1100, 0001, 0010, 0100, 1000.
- Enabled, legal pattern: normal behaviour.
- Enabled, any other pattern on a write: no RAM byte is modified, ack is still issued, and o_sel_err is set. o_sel_err stays 1 until reset.
- Enabled, reads are never checked.
- Disabled: o_sel_err is tied to 0 and any sel pattern writes exactly the selected lanes.

Test Plan:
1. WAIT=1: write adr=0x0000_0010, dat=0xDEADBEEF, sel=1111 -> ack high on the 2nd edge after cyc, for 1 cycle. Then read adr=0x10 -> o_wb_rdt=0xDEADBEEF.
2. Byte and half lanes: preload word 4 = 0x11223344.
   - Write sel=0100, dat=0x00AA0000 -> read returns 0x11AA3344.
   - Then write sel=1100, dat=0x5566_0000 -> read returns 0x55663344.
3. Abort: cyc high for 1 cycle of WAIT (WAIT=3), then low -> no ack and memory unchanged. Next full request -> ack after 4 cycles.
4. Async reset: assert i_rst mid-WAIT with a write pending -> o_wb_ack=0 immediately and the target word keeps its old value. Release reset, then read -> old data.
5. WAIT=0 back-to-back: reads of words 0, 1, 2 with cyc dropping on each ack -> each ack 1 cycle after cyc sampled, o_wb_rdt correct per word. Also adr=0x0000_0400 with AW=8 aliases to word 0.
6. SERV_WB_RAM_SEL_CHECK_EN defined: write sel=0110 -> ack issued, word unchanged, o_sel_err=1 and sticky. A following legal write updates normally with o_sel_err still 1.
